frequency_result_dumper: RTL

- Downstream of the frequency analyzer manager's analyzer bank.
- On a dump command it snapshots the f1/f2 action-time values of every sampled pixel.
- It streams the snapshot as 32-bit words over a valid/ready interface to the AXI/DMA side.
- It raises a sticky irq when the dump completes.
- Implements the "data send" path for the DUMP_FREQUENCIES_REQUEST command.

---
 rtl/frequency_result_dumper_pkg.sv | 21 ++
 rtl/frequency_result_dumper_if.sv | 25 ++
 rtl/frequency_result_dumper.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/frequency_result_dumper_pkg.sv
// Shared types and constants for the frequency result dumper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frequency_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] HEADER_MAGIC         = 16'hF0A5;
    localparam logic [31:0] DEFAULT_DUMP_REQUEST = 32'd666;

    // Stream length of one dump: f1/f2 per pixel plus the optional header.
    function automatic int unsigned words_per_dump(input int unsigned num_pixels,
                                                   input bit          header_en);
        return 2 * num_pixels + (header_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/frequency_result_dumper_if.sv
// Command input and result stream of the frequency result dumper.
// Latency: n/a (wires only).
// Backpressure: out_ready stalls the stream; commands have no backpressure.
interface frequency_result_dumper_if #(
    parameter int VALUE_WIDTH = 32
);
    logic                   cmd_valid;
    logic [31:0]            cmd_data;
    logic [VALUE_WIDTH-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;

    // Dumper side.
    modport slave (
        input  cmd_valid, cmd_data, out_ready,
        output out_data, out_valid, out_last
    );

    // Command issuer / stream consumer side.
    modport master (
        output cmd_valid, cmd_data, out_ready,
        input  out_data, out_valid, out_last
    );
endinterface

// File: rtl/frequency_result_dumper.sv
// Snapshots all f1/f2 action-time values on a dump command and streams them out as words.
// Latency: first word valid 1 cycle after the accepting command edge; one word per ready cycle.
// Backpressure: out_ready low holds out_data/out_last; dump commands while busy are dropped (overrun).
// Optional: define FREQUENCY_DUMP_HEADER_EN to prepend {magic, seq, word count} to each dump.
module frequency_result_dumper
    import frequency_dump_pkg::*;
#(
    parameter int          NUM_PIXELS               = 3,
    parameter int          VALUE_WIDTH              = 32,
    parameter logic [31:0] DUMP_FREQUENCIES_REQUEST = DEFAULT_DUMP_REQUEST
) (
    input  logic                                  clock,
    input  logic                                  reset,
    frequency_result_dumper_if.slave              bus,
    input  logic [2*NUM_PIXELS*VALUE_WIDTH-1:0]   values,
    output logic                                  busy,
    output logic                                  irq,
    input  logic                                  irq_ack,
    output logic                                  overrun
);

    localparam int SLOTS = 2 * NUM_PIXELS;
`ifdef FREQUENCY_DUMP_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam int WORDS = int'(words_per_dump(NUM_PIXELS, HDR_EN));
    // Header mode never exceeds index SLOTS, so this width covers both builds.
    localparam int IDX_W = $clog2(SLOTS + 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [VALUE_WIDTH-1:0] shadow_q [SLOTS];
    logic [VALUE_WIDTH-1:0] shadow_d [SLOTS];
    logic [7:0]             seq_q, seq_d;
    logic                   irq_q, irq_d;
    logic                   overrun_q, overrun_d;

    logic                   cmd_hit;
    logic                   last_word;
    logic                   xfer;
    logic [IDX_W-1:0]       slot;
    logic [VALUE_WIDTH-1:0] word;

    assign cmd_hit   = bus.cmd_valid && (bus.cmd_data == DUMP_FREQUENCIES_REQUEST);
    assign last_word = (index_q == IDX_W'(WORDS - 1));
    assign xfer      = (state_q == SEND) && bus.out_ready;

    // Select the word at the current stream position (header first when enabled).
    always_comb begin
`ifdef FREQUENCY_DUMP_HEADER_EN
        slot = index_q - 1'b1;
        if (index_q == '0) begin
            word = VALUE_WIDTH'({HEADER_MAGIC, seq_q, 8'(SLOTS)});
        end else begin
            word = shadow_q[slot];
        end
`else
        slot = index_q;
        word = shadow_q[slot];
`endif
    end

    // Stream outputs are pure functions of registered state, so they stay stable while stalled.
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = (state_q == SEND) ? word : '0;
    assign bus.out_last  = (state_q == SEND) && last_word;
    assign busy          = (state_q != IDLE);
    assign irq           = irq_q;
    assign overrun       = overrun_q;

    // Next-state logic; set events on irq/overrun are applied after the ack clear so they win.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        shadow_d  = shadow_q;
        seq_d     = seq_q;
        irq_d     = irq_q;
        overrun_d = overrun_q;

        if (irq_ack) begin
            irq_d     = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_hit) begin
                    for (int k = 0; k < SLOTS; k++) begin
                        shadow_d[k] = values[k*VALUE_WIDTH +: VALUE_WIDTH];
                    end
                    index_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cmd_hit) begin
                    overrun_d = 1'b1;
                end
                if (xfer) begin
                    if (last_word) begin
                        // irq rises on entering DONE so it is visible while busy is still high.
                        irq_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (cmd_hit) begin
                    overrun_d = 1'b1;
                end
                irq_d   = 1'b1;
                seq_d   = seq_q + 8'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any dump in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            shadow_q  <= '{default: '0};
            seq_q     <= '0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            shadow_q  <= shadow_d;
            seq_q     <= seq_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
